// File: rtl/i2c_cmd_issuer_pkg.sv
// Shared types and sizing helpers for the I2C command issuer.
// State encodings are fixed so the FSM value stays readable in waveforms.
package i2c_cmd_issuer_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  // Counter width able to hold 0..timeout-1.
  function automatic int cnt_w(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/i2c_cmd_issuer_if.sv
// Command-side valid/ready port and master-side start/addr/data/ready port.
// The issuer uses the slave modport; whatever feeds it and models the I2C master uses master.
interface i2c_cmd_issuer_if
  import i2c_cmd_issuer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;
  logic              m_start;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport slave (
    input  s_valid, s_addr, s_data, m_ready,
    output s_ready, m_start, m_addr, m_data
  );

  modport master (
    output s_valid, s_addr, s_data, m_ready,
    input  s_ready, m_start, m_addr, m_data
  );

endinterface

// File: rtl/i2c_cmd_issuer_fifo.sv
// Synchronous FIFO, DEPTH x W; data visible at rdat_o one cycle after push.
// Push ignored when full, pop ignored when empty; level is the registered occupancy.
module i2c_cmd_issuer_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           wdat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full_o  = cnt_q[AW];
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign rdat_o  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdat_i;
  end

endmodule

// File: rtl/i2c_cmd_issuer.sv
// Buffers (addr,data) writes and issues them one at a time to the I2C master, aborting hung ones.
// Push-to-m_start two edges from an empty FIFO; s_ready drops only when the FIFO is full.
module i2c_cmd_issuer
  import i2c_cmd_issuer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  i2c_cmd_issuer_if.slave        bus,
  input  logic                   clr_err_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   busy_o,
  output logic                   txn_done_o,
  output logic                   timeout_err_o
);

  localparam int CNT_W = cnt_w(TIMEOUT);
  localparam int W     = ADDR_W + DATA_W;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              m_start_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_data_q;
  logic              txn_done_q;
  logic              timeout_err_q;

  logic              fifo_full, fifo_empty, push, pop;
  logic [W-1:0]      head;
  logic              timeout_hit, abort;

  // Reset gates s_ready so nothing is accepted while the FIFO is held empty.
  assign bus.s_ready = !fifo_full && rst_ni;
  assign push        = bus.s_valid && bus.s_ready;
  assign pop         = (state_q == ST_IDLE) && !fifo_empty && bus.m_ready;

  i2c_cmd_issuer_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdat_i  ({bus.s_addr, bus.s_data}),
    .pop_i   (pop),
    .rdat_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  // A real state change on the same edge takes priority over the timeout.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign abort       = timeout_hit &&
                       (((state_q == ST_ISSUE) && bus.m_ready) ||
                        ((state_q == ST_BUSY) && !bus.m_ready));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      m_start_q     <= 1'b0;
      m_addr_q      <= '0;
      m_data_q      <= '0;
      txn_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      txn_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (pop) begin
            {m_addr_q, m_data_q} <= head;
            m_start_q            <= 1'b1;
            state_q              <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q <= cnt_q + 1'b1;
          if (!bus.m_ready) begin
            m_start_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_BUSY;
          end else if (abort) begin
            m_start_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.m_ready) begin
            txn_done_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (abort) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          m_start_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= ST_IDLE;
        end
      endcase

      if (clr_err_i) begin
        timeout_err_q <= 1'b0;
      end else if (abort) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign bus.m_start   = m_start_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_data    = m_data_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign txn_done_o    = txn_done_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_i2c_cmd_issuer.sv
// Randomized and directed stimulus against a transaction-level queue model of the issuer.
// A behavioural I2C master drops m_ready one cycle after seeing m_start and returns it after N cycles.
module tb_i2c_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int TO    = 64;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_err = 1'b0;
  logic [2:0] level;
  logic       busy, txn_done, terr;

  always #5 clk = ~clk;

  i2c_cmd_issuer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  i2c_cmd_issuer #(
    .DEPTH   (DEPTH),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus           (bus),
    .clr_err_i     (clr_err),
    .level_o       (level),
    .busy_o        (busy),
    .txn_done_o    (txn_done),
    .timeout_err_o (terr)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of accepted commands, phase 0 idle / 1 issuing / 2 master busy,
  // and the cycle number at which the current phase began.
  cmd_t mq[$];
  int   ph = 0;
  int   cyc = 0;
  int   t_enter = 0;
  bit   e_start = 0, e_done = 0, e_err = 0;
  cmd_t e_cmd = '0;

  // Environment state.
  cmd_t pend[$];
  cmd_t seen[$];
  int   m_n = 20;
  int   m_cnt = 0;
  bit   hang = 0;
  bit   rnd_n = 0;
  int   rnd_rate = 0;
  bit   clr_pulse = 0;
  bit   clr_on_abort = 0;
  int   ndone = 0;
  int   nstart = 0;
  bit   prev_start = 0;

  function automatic cmd_t rnd_cmd();
    logic [31:0] r;
    r = $urandom;
    return r[AW+DW-1:0];
  endfunction

  function automatic cmd_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.a = a;
    c.d = d;
    return c;
  endfunction

  task automatic model_reset();
    mq.delete();
    ph = 0;
    e_start = 0;
    e_done = 0;
    e_err = 0;
    e_cmd = '0;
  endtask

  task automatic model_step();
    bit   accept, abort;
    cmd_t inc;
    accept = bus.s_valid && (mq.size() < DEPTH);
    inc    = {bus.s_addr, bus.s_data};
    abort  = 0;
    cyc++;
    e_done = 0;
    if (ph == 0) begin
      if (mq.size() > 0 && bus.m_ready) begin
        e_cmd   = mq.pop_front();
        e_start = 1;
        ph      = 1;
        t_enter = cyc;
      end
    end else if (ph == 1) begin
      if (!bus.m_ready) begin
        e_start = 0;
        ph      = 2;
        t_enter = cyc;
      end else if (cyc - t_enter == TO) begin
        abort = 1;
      end
    end else begin
      if (bus.m_ready) begin
        e_done = 1;
        ph     = 0;
      end else if (cyc - t_enter == TO) begin
        abort = 1;
      end
    end
    if (abort) begin
      ph      = 0;
      e_start = 0;
    end
    if (clr_err) e_err = 0;
    else if (abort) e_err = 1;
    if (accept) begin
      mq.push_back(inc);
      if (pend.size() > 0) void'(pend.pop_front());
    end
  endtask

  task automatic compare();
    check("m_start", 32'(bus.m_start), 32'(e_start));
    check("m_addr", 32'(bus.m_addr), 32'(e_cmd.a));
    check("m_data", 32'(bus.m_data), 32'(e_cmd.d));
    check("level", 32'(level), 32'(mq.size()));
    check("busy", 32'(busy), 32'(ph != 0));
    check("txn_done", 32'(txn_done), 32'(e_done));
    check("timeout_err", 32'(terr), 32'(e_err));
    check("s_ready", 32'(bus.s_ready), 32'(mq.size() < DEPTH));
  endtask

  task automatic master();
    if (txn_done) ndone++;
    if (bus.m_start && !prev_start) nstart++;
    prev_start = bus.m_start;
    if (hang) begin
      bus.m_ready = 1'b1;
    end else if (bus.m_ready && bus.m_start) begin
      bus.m_ready = 1'b0;
      if (rnd_n) m_cnt = ($urandom_range(0, 7) == 0) ? 70 : int'($urandom_range(1, 6));
      else       m_cnt = m_n;
      seen.push_back({bus.m_addr, bus.m_data});
    end else if (!bus.m_ready) begin
      m_cnt--;
      if (m_cnt <= 0) bus.m_ready = 1'b1;
    end
  endtask

  task automatic drive();
    cmd_t junk;
    if (rnd_rate > 0 && pend.size() == 0 && $urandom_range(0, 99) < rnd_rate)
      pend.push_back(rnd_cmd());
    bus.s_valid = (pend.size() > 0);
    junk = rnd_cmd();
    if (pend.size() > 0) {bus.s_addr, bus.s_data} = pend[0];
    else                 {bus.s_addr, bus.s_data} = junk;
    clr_err = clr_pulse ||
              (clr_on_abort && ph == 2 && !bus.m_ready && (cyc + 1 - t_enter) == TO) ||
              (rnd_rate > 0 && $urandom_range(0, 49) == 0);
    clr_pulse = 0;
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    if (rst_n) compare();
    master();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string tag, input int limit);
    int k;
    k = 0;
    while ((pend.size() > 0 || mq.size() > 0 || ph != 0) && k < limit) begin
      step();
      k++;
    end
    check(tag, 32'(k < limit), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, hi;
    bit   saw_full, did6;
    cmd_t c5[5];
    cmd_t got;

    bus.s_valid = 1'b0;
    bus.s_addr  = '0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_m_start", 32'(bus.m_start), 32'd0);
    check("rst_m_addr", 32'(bus.m_addr), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_txn_done", 32'(txn_done), 32'd0);
    check("rst_timeout_err", 32'(terr), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_s_ready", 32'(bus.s_ready), 32'd1);

    // Single command, latency and completion
    m_n = 20;
    ndone = 0;
    nstart = 0;
    pend.push_back(mk(7'h50, 8'hA5));
    step();
    check("t1_level_after_push", 32'(level), 32'd1);
    check("t1_no_start_yet", 32'(bus.m_start), 32'd0);
    step();
    check("t1_start", 32'(bus.m_start), 32'd1);
    check("t1_level_after_load", 32'(level), 32'd0);
    check("t1_m_addr", 32'(bus.m_addr), 32'h50);
    check("t1_m_data", 32'(bus.m_data), 32'hA5);
    drain("t1_drain", 200);
    check("t1_done_count", 32'(ndone), 32'd1);
    check("t1_start_count", 32'(nstart), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_hold_addr", 32'(bus.m_addr), 32'h50);

    // Five back-to-back commands into a 4-deep FIFO while the master is briefly busy
    m_n = 3;
    ndone = 0;
    seen.delete();
    for (int i = 0; i < 5; i++) begin
      c5[i] = rnd_cmd();
      pend.push_back(c5[i]);
    end
    bus.m_ready = 1'b0;
    m_cnt = 8;
    saw_full = 0;
    did6 = 0;
    k = 0;
    while ((pend.size() > 0 || mq.size() > 0 || ph != 0) && k < 500) begin
      if (level == 3'd4) begin
        check("t2_full_s_ready", 32'(bus.s_ready), 32'd0);
        saw_full = 1;
        if (!did6 && bus.m_ready && ph == 0) begin
          did6 = 1;
          step();
          check("t6_level_after_pop", 32'(level), 32'd3);
          check("t6_s_ready_reopen", 32'(bus.s_ready), 32'd1);
          step();
          check("t6_level_refill", 32'(level), 32'd4);
          k += 2;
          continue;
        end
      end
      step();
      k++;
    end
    check("t2_bound", 32'(k < 500), 32'd1);
    check("t2_saw_full", 32'(saw_full), 32'd1);
    check("t6_seen", 32'(did6), 32'd1);
    check("t2_done_count", 32'(ndone), 32'd5);
    check("t2_issued_count", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      got = (i < seen.size()) ? seen[i] : '0;
      check($sformatf("t2_order%0d", i), 32'(got), 32'(c5[i]));
    end

    // Master never drops m_ready: abort from ISSUE, next command still issues
    hang = 1;
    ndone = 0;
    pend.push_back(mk(7'h11, 8'h22));
    pend.push_back(mk(7'h33, 8'h44));
    k = 0;
    hi = 0;
    while (!terr && k < 200) begin
      step();
      if (bus.m_start) hi++;
      k++;
    end
    check("t3_err_set", 32'(terr), 32'd1);
    check("t3_start_cycles", 32'(hi), 32'(TO));
    check("t3_start_dropped", 32'(bus.m_start), 32'd0);
    check("t3_no_done", 32'(ndone), 32'd0);
    step();
    check("t3_next_issue", 32'(bus.m_start), 32'd1);
    check("t3_next_addr", 32'(bus.m_addr), 32'h33);
    hang = 0;
    drain("t3_drain", 300);
    check("t3_done_count", 32'(ndone), 32'd1);
    check("t3_err_held", 32'(terr), 32'd1);
    clr_pulse = 1;
    step();
    check("t3_err_cleared", 32'(terr), 32'd0);

    // Master hangs in BUSY: abort, then clr_err coinciding with a second abort
    m_n = 100;
    ndone = 0;
    nstart = 0;
    pend.push_back(rnd_cmd());
    pend.push_back(rnd_cmd());
    k = 0;
    while (!terr && k < 300) begin
      step();
      k++;
    end
    check("t4_err_set", 32'(terr), 32'd1);
    check("t4_busy_cleared", 32'(busy), 32'd0);
    clr_on_abort = 1;
    k = 0;
    while (!(nstart >= 2 && ph == 0) && k < 400) begin
      step();
      k++;
    end
    check("t4_bound", 32'(k < 400), 32'd1);
    check("t4_clr_wins", 32'(terr), 32'd0);
    check("t4_no_done", 32'(ndone), 32'd0);
    clr_on_abort = 0;
    m_n = 5;
    run(60);

    // Asynchronous reset during BUSY with three queued
    m_n = 40;
    for (int i = 0; i < 4; i++) pend.push_back(rnd_cmd());
    k = 0;
    while (!(ph == 2 && mq.size() == 3) && k < 100) begin
      step();
      k++;
    end
    check("t5_reached_busy", 32'(busy), 32'd1);
    check("t5_queued", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_m_start", 32'(bus.m_start), 32'd0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_s_ready", 32'(bus.s_ready), 32'd0);
    pend.delete();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    m_cnt = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    nstart = 0;
    run(30);
    check("t5_no_issue", 32'(nstart), 32'd0);

    // Random traffic with random master latency, occasional aborts and clears
    rnd_n = 1;
    rnd_rate = 40;
    run(1500);
    rnd_rate = 0;
    drain("rnd_drain", 2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
